// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one sequential multiplier core
//
// Shares a single sequential Booth multiplier among NUM_REQ requesters.
// A request is accepted from the round-robin winner, its operands are loaded
// into the core, and the core is started with a one-cycle pulse. The product
// goes back to the granted requester. A watchdog aborts a core that never
// reports done and returns an error response instead.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready per-requester operand handshake (ready is one-hot or zero)
//   req_a/req_b     packed operands, slice i belongs to requester i
//   rsp_valid/ready per-requester response handshake (valid is one-hot or zero)
//   rsp_product     shared signed product, 2*WIDTH bits
//   rsp_error       response is a watchdog abort
//   mul_a/mul_b     operands to the core, held from load until the next accept
//   mul_start       one-cycle start pulse to the core
//   mul_ready       core done pulse, mul_product valid with it
//   mul_abort       one-cycle pulse meant to be ORed into the core reset
//   busy            high in every state except idle
//   grant_id        current or last granted requester
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 5,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic                       rsp_error,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    output logic                       mul_start,
    input  logic                       mul_ready,
    input  logic [2*WIDTH-1:0]         mul_product,
    output logic                       mul_abort,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_ABORT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       rr_ptr_q;
    logic [IDW-1:0]       grant_id_q;
    logic [TW-1:0]        timer_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [2*WIDTH-1:0]   rsp_product_q;
    logic                 rsp_error_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 mul_start_q;
    logic                 mul_abort_q;
    logic                 busy_q;

    logic                 any_valid;
    logic [IDW-1:0]       win;
    logic [IDW:0]         cand;
    logic [WIDTH-1:0]     win_a;
    logic [WIDTH-1:0]     win_b;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [IDW-1:0]       rr_next;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    // cand carries one extra bit so the wrap subtraction never overflows.
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!any_valid && req_valid[cand[IDW-1:0]]) begin
                any_valid = 1'b1;
                win       = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i)) begin
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // The only combinational output: the winner sees ready while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && any_valid) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        grant_oh             = '0;
        grant_oh[grant_id_q] = 1'b1;
    end

    assign rr_next = (grant_id_q == IDW'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            timer_q       <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_product_q <= '0;
            rsp_error_q   <= 1'b0;
            rsp_valid_q   <= '0;
            mul_start_q   <= 1'b0;
            mul_abort_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Start and abort are single-cycle pulses unless re-armed below.
            mul_start_q <= 1'b0;
            mul_abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_id_q  <= win;
                        mul_a_q     <= win_a;
                        mul_b_q     <= win_b;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    timer_q <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    timer_q <= timer_q + 1'b1;
                    // A done pulse on the watchdog's last cycle still counts.
                    if (mul_ready) begin
                        rsp_product_q <= mul_product;
                        rsp_error_q   <= 1'b0;
                        rsp_valid_q   <= grant_oh;
                        state_q       <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT-1)) begin
                        mul_abort_q <= 1'b1;
                        state_q     <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    rsp_product_q <= '0;
                    rsp_error_q   <= 1'b1;
                    rsp_valid_q   <= grant_oh;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[grant_id_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_next;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    rsp_error_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign rsp_error   = rsp_error_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_start   = mul_start_q;
    assign mul_abort   = mul_abort_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;
    localparam int N = 4;
    localparam int W = 5;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [2*W-1:0] rsp_product;
    logic           rsp_error;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_start;
    logic           mul_ready;
    logic [2*W-1:0] mul_product;
    logic           mul_abort;
    logic           busy;
    logic [1:0]     grant_id;

    mul_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
        .rsp_error(rsp_error), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_ready(mul_ready), .mul_product(mul_product), .mul_abort(mul_abort),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;

    exp_t           sb[$];
    int             gorder[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             rsp_cnt = 0;
    int             start_cnt = 0;
    int             abort_cnt = 0;
    logic           exp_start = 1'b0;
    logic           prev_mr = 1'b0;
    logic [2*W-1:0] prod_by_id [N];
    int             core_delay = 12;
    logic           core_hang = 1'b0;

    function automatic logic [2*W-1:0] smul(logic [W-1:0] a, logic [W-1:0] b);
        int ia;
        int ib;
        int p;
        ia = $signed(a);
        ib = $signed(b);
        p  = ia * ib;
        return p[2*W-1:0];
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: product of the operands the DUT presents, after core_delay cycles.
    initial begin
        int             cd;
        logic [2*W-1:0] cprod;
        cd          = -1;
        cprod       = '0;
        mul_ready   = 1'b0;
        mul_product = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_ready = 1'b0;
            if (rst || mul_abort) begin
                cd = -1;
            end else begin
                if (cd == 0) begin
                    mul_ready   = 1'b1;
                    mul_product = cprod;
                    cd          = -1;
                end else if (cd > 0) begin
                    cd--;
                end
                if (mul_start && !core_hang) begin
                    cd    = core_delay - 1;
                    cprod = smul(mul_a, mul_b);
                end
            end
        end
    end

    task automatic post(int i, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    // One clock: observe at negedge, then drop accepted valids after the edge.
    task automatic tick();
        logic [N-1:0] acc;
        exp_t         e;
        int           id;
        @(negedge clk);
        if (prev_mr) check("rsp_latency", 32'(rsp_valid != 0), 32'd1);
        if (exp_start) check("start_latency", 32'(mul_start), 32'd1);
        exp_start = 1'b0;
        if (mul_abort) abort_cnt++;
        if (mul_start) start_cnt++;
        if ((rsp_valid & rsp_ready) != 0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_valid), 32'(4'b0001 << e.id));
                check("rsp_product", 32'(rsp_product), 32'(e.prod));
                check("rsp_error", 32'(rsp_error), 32'(e.err));
                prod_by_id[e.id] = rsp_product;
                rsp_cnt++;
            end
        end
        acc = req_valid & req_ready;
        if (acc != 0) begin
            id = 0;
            for (int i = 0; i < N; i++) if (acc[i]) id = i;
            e.id   = id;
            e.err  = core_hang;
            e.prod = core_hang ? '0 : smul(req_a[id*W +: W], req_b[id*W +: W]);
            sb.push_back(e);
            gorder.push_back(id);
            exp_start = 1'b1;
        end
        prev_mr = mul_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic drain(int budget);
        int c;
        c = 0;
        while ((req_valid != 0 || sb.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        check("drain_done", 32'(req_valid != 0 || sb.size() != 0), 32'd0);
    endtask

    initial begin
        int c;
        int base;
        int s;
        int exp_order[] = '{1, 3, 0, 3, 0, 2, 1, 0, 3, 0, 1, 2, 3, 0, 1, 2, 3, 2, 3, 0, 1, 2, 1, 3};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_product", 32'(rsp_product), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_abort", 32'(mul_abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request, 12-cycle core.
        post(1, 5'd3, 5'd7);
        #1;
        check("ready_single", 32'(req_ready), 32'b0010);
        tick();
        check("ready_dropped", 32'(req_ready), 32'd0);
        drain(100);
        check("prod_21", 32'(prod_by_id[1]), 32'd21);

        // Signed operands; rr_ptr=2 makes requester 3 win before 0.
        post(3, 5'b10000, 5'b10000);
        post(0, 5'b11011, 5'b00110);
        drain(200);
        check("prod_256", 32'(prod_by_id[3]), 32'h100);
        check("prod_m30", 32'(prod_by_id[0]), 32'h3E2);
        post(3, 5'd1, 5'd1);
        drain(100);

        // Round robin from rr_ptr=0 with 0101, then 1 joins during 2's run.
        post(0, 5'($urandom), 5'($urandom));
        post(2, 5'($urandom), 5'($urandom));
        c = 0;
        while (gorder.size() < 6 && c < 200) begin tick(); c++; end
        check("rr_wait", 32'(gorder.size()), 32'd6);
        post(1, 5'($urandom), 5'($urandom));
        drain(200);
        post(0, 5'($urandom), 5'($urandom));
        drain(100);
        post(3, 5'($urandom), 5'($urandom));
        drain(100);

        // All four requesters held continuously for five grants.
        base = gorder.size();
        for (int i = 0; i < N; i++) post(i, 5'($urandom), 5'($urandom));
        c = 0;
        while (gorder.size() < base + 5 && c < 400) begin
            tick();
            c++;
            if (gorder.size() < base + 5)
                for (int i = 0; i < N; i++)
                    if (!req_valid[i]) post(i, 5'($urandom), 5'($urandom));
        end
        drain(400);

        // Hung core: watchdog abort with an error response.
        core_hang = 1'b1;
        abort_cnt = 0;
        post(2, 5'd4, 5'd4);
        drain(200);
        check("abort_pulses", 32'(abort_cnt), 32'd1);

        // Done pulse on the watchdog's last cycle wins.
        core_hang  = 1'b0;
        core_delay = 32;
        abort_cnt  = 0;
        post(3, 5'd5, 5'd3);
        drain(200);
        check("coincide_no_abort", 32'(abort_cnt), 32'd0);
        check("coincide_prod", 32'(prod_by_id[3]), 32'd15);

        // Backpressure with another requester waiting.
        core_delay = 3;
        rsp_ready  = '0;
        post(0, 5'd9, 5'd2);
        c = 0;
        while (rsp_valid == 0 && c < 60) begin tick(); c++; end
        check("bp_arrive", 32'(rsp_valid), 32'b0001);
        post(1, 5'd2, 5'd2);
        s = start_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'b0001);
            check("bp_product", 32'(rsp_product), 32'd18);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        check("bp_no_start", 32'(start_cnt - s), 32'd0);
        rsp_ready = '1;
        drain(100);

        // Reset during the run: outputs clear at once, no response.
        core_hang = 1'b1;
        post(2, 5'd7, 5'd7);
        for (int k = 0; k < 4; k++) tick();
        check("busy_before_rst", 32'(busy), 32'd1);
        s = rsp_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_outs", 32'({rsp_valid, req_ready, mul_start, mul_abort, rsp_error}), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        core_hang = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_quiet", 32'(rsp_valid), 32'd0);
        end
        check("post_rst_no_rsp", 32'(rsp_cnt), 32'(s));
        post(1, 5'd6, 5'd5);
        post(3, 5'd2, 5'd3);
        drain(200);
        check("post_rst_prod", 32'(prod_by_id[1]), 32'd30);

        check("order_len", 32'(gorder.size()), 32'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < gorder.size(); i++)
            check($sformatf("grant_order[%0d]", i), 32'(gorder[i]), 32'(exp_order[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential Booth multiplier core among NUM_REQ requesters using round-robin arbitration.
- Accepts operand pairs over valid/ready, loads the winner's operands and pulses the core's start (enable_fsm).
- Waits for the core's ready pulse, then returns the product to the granted requester over a per-requester valid/ready response channel.
- A watchdog aborts a hung core and returns an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 5, operand width in bits, two's complement; product is 2*WIDTH.
- TIMEOUT, 32, maximum cycles in S_RUN before abort (>=4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed multiplicands; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  packed multipliers.
- rsp_valid  out  NUM_REQ  per-requester response valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_product  out  2*WIDTH  shared response data.
- rsp_error  out  1  response is a timeout abort; qualified by rsp_valid.
- mul_a, mul_b  out  WIDTH each  operands to the core; held stable from load until the next accept.
- mul_start  out  1  one-cycle start pulse to the core's enable_fsm.
- mul_ready  in  1  core done pulse (one cycle).
- mul_product  in  2*WIDTH  core result; valid while mul_ready=1.
- mul_abort  out  1  one-cycle pulse; the integrator ORs it into the core reset.
- busy  out  1  high in every state except S_IDLE.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.

Behaviour:
- Reset values: state S_IDLE, rr_ptr=0, grant_id=0, mul_a=mul_b=0, rsp_product=0, timer=0.
- Reset values (outputs): req_ready, rsp_valid, rsp_error, mul_start, mul_abort and busy are all 0.
- Reset mid-operation returns immediately to S_IDLE. No response is produced for the in-flight request.
- Arbitration: search req_valid starting at index rr_ptr, ascending with wrap. The first set bit wins.
- S_IDLE:
  - req_ready[win] = 1 combinationally when any req_valid is set.
  - At the accepting edge, latch grant_id=win and mul_a/mul_b from slice win, then go to S_START.
  - A requester must hold valid and operands until accepted. Non-granted requesters see req_ready=0.
- S_START: mul_start=1 for exactly one cycle; timer cleared; next state S_RUN. mul_ready is ignored in S_START.
- S_RUN: timer increments each cycle.
  - mul_ready=1: latch rsp_product=mul_product, rsp_error=0, go to S_RESP.
  - Otherwise, timer==TIMEOUT-1: go to S_ABORT.
  - If mul_ready and timeout coincide, mul_ready wins.
- S_ABORT: mul_abort=1 for one cycle; rsp_product=0, rsp_error=1; next state S_RESP.
- S_RESP:
  - rsp_valid[grant_id]=1; rsp_product and rsp_error are held stable.
  - On rsp_ready[grant_id]=1: set rr_ptr=(grant_id+1) mod NUM_REQ and go to S_IDLE. Other rsp_ready bits are ignored.
  - Backpressure is unbounded; no new grant is issued while in S_RESP.
  - A stray mul_ready outside S_RUN is ignored.
- Latency: accept at edge T gives mul_start high in cycle T+1. Core done sampled at edge D makes rsp_valid high from cycle D+1.
- Minimum request-to-request throughput is 4 cycles plus core latency.
- Outputs are Moore: registered state or registered data only. req_ready is the sole combinational output.
- Arithmetic: no reformatting. The product is passed through at 2*WIDTH as a signed value.
- Undefined states recover to S_IDLE with all outputs deasserted.

Test Plan:
- Single request: core model with a 12-cycle ready delay; req 1, a=3, b=7.
  - Expect req_ready[1] for 1 cycle, then mul_start 1 cycle later.
  - Expect rsp_valid[1] with rsp_product=21 and rsp_error=0 one cycle after mul_ready; rr_ptr becomes 2.
- Signed operands: a=-16, b=-16 (5'b10000 each) -> rsp_product=256 (10'h100). a=-5, b=6 -> rsp_product=-30 (10'h3E2).
- Round robin: rr_ptr=0, req_valid=4'b0101 held.
  - Expect grant order 0, then 2. Assert req 1 during req 2's run; it is granted next, then wrap to 0.
  - All four requesters asserted continuously: expect grant order 0,1,2,3,0.
- Timeout: core model never asserts ready.
  - After TIMEOUT cycles in S_RUN, expect mul_abort pulsed for exactly 1 cycle.
  - Then rsp_valid[g]=1 with rsp_error=1 and rsp_product=0.
  - mul_ready on the same cycle as the timeout: expect a normal product and no abort.
- Backpressure: hold rsp_ready low for 10 cycles while another req_valid is high.
  - rsp_valid and rsp_product must stay stable, with no req_ready and no mul_start.
  - Release -> S_IDLE, then the next grant.
- Reset mid-run: assert rst during S_RUN.
  - All outputs go to 0 asynchronously and no rsp_valid is produced.
  - A subsequent request completes normally with grant from rr_ptr=0.
